// File: rtl/calculator_pkg.sv
// Shared types and widths for the calculator SRAM datapath and its port arbiter.
// Pure declarations; no timing or backpressure of its own.
package calculator_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 64;
   localparam int HALF_W = DATA_W / 2;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      S_ARB_IDLE = 2'd0,
      S_ARB_OWN0 = 2'd1,
      S_ARB_OWN1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Read-return tag captured at the transfer so an ownership switch cannot misroute it.
   typedef struct packed {
      logic vld;
      logic owner;
   } rd_tag_t;

   function automatic arb_state_t own_state(input logic owner);
      return owner ? S_ARB_OWN1 : S_ARB_OWN0;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Two-way round-robin pick: single requester wins outright, a tie goes to the non-last owner.
// Combinational, zero latency; no backpressure.
module arb_rr_pick (
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       next_owner
);

   always_comb begin
      next_owner = last_owner;
      case (req)
         2'b01:   next_owner = 1'b0;
         2'b10:   next_owner = 1'b1;
         2'b11:   next_owner = ~last_owner;
         default: next_owner = last_owner;
      endcase
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the calculator controller and host loader onto one split-bank SRAM port.
// Grant one cycle after request, read data one cycle after transfer; losers wait while req held.
module sram_port_arbiter
   import calculator_pkg::*;
#(
   parameter int BURST_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_i,
   input  logic [1:0]        lock_i,
   input  logic [1:0]        we_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic [1:0]        gnt_o,
   output logic [1:0]        rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [HALF_W-1:0] mem_wdata_lo_o,
   output logic [HALF_W-1:0] mem_wdata_hi_o,
   input  logic [HALF_W-1:0] mem_rdata_lo_i,
   input  logic [HALF_W-1:0] mem_rdata_hi_i,
   output logic [CNT_W-1:0]  xfer_cnt0_o,
   output logic [CNT_W-1:0]  xfer_cnt1_o
);

   localparam int BC_W = $clog2(BURST_MAX + 1);
   localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_MAX - 1);

   arb_state_t       state_q, state_d;
   logic             last_owner_q;
   logic [BC_W-1:0]  burst_cnt_q;
   rd_tag_t          rd_tag_q;
   mem_req_t         mem_req;
   logic [CNT_W-1:0] xfer_cnt0_q, xfer_cnt1_q;

   logic own_vld, cur_owner, oth_owner, xfer, burst_done, pick_owner;

   assign own_vld    = (state_q != S_ARB_IDLE);
   assign cur_owner  = (state_q == S_ARB_OWN1);
   assign oth_owner  = ~cur_owner;
   assign xfer       = own_vld & req_i[cur_owner];
   assign burst_done = xfer & (burst_cnt_q == BURST_LAST);

   arb_rr_pick u_rr_pick (
      .req        (req_i),
      .last_owner (last_owner_q),
      .next_owner (pick_owner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_ARB_IDLE;
         last_owner_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_d != state_q && state_d != S_ARB_IDLE)
            last_owner_q <= (state_d == S_ARB_OWN1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ARB_IDLE: begin
            if (|req_i)
               state_d = own_state(pick_owner);
         end
         S_ARB_OWN0, S_ARB_OWN1: begin
            if (!req_i[cur_owner])
               state_d = req_i[oth_owner] ? own_state(oth_owner) : S_ARB_IDLE;
            else if (burst_done && !lock_i[cur_owner] && req_i[oth_owner])
               state_d = own_state(oth_owner);
         end
         default: state_d = S_ARB_IDLE;
      endcase
   end

   always_comb begin
      gnt_o         = 2'b00;
      mem_req       = '0;
      mem_req.addr  = cur_owner ? addr1_i : addr0_i;
      mem_req.wdata = cur_owner ? wdata1_i : wdata0_i;
      case (state_q)
         S_ARB_OWN0: gnt_o = 2'b01;
         S_ARB_OWN1: gnt_o = 2'b10;
         default:    gnt_o = 2'b00;
      endcase
      if (xfer) begin
         mem_req.en = 1'b1;
         mem_req.we = we_i[cur_owner];
      end
   end

   // A full burst that does not hand over (locked or uncontested) restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         burst_cnt_q <= '0;
      else if (state_d != state_q || burst_done)
         burst_cnt_q <= '0;
      else if (xfer)
         burst_cnt_q <= burst_cnt_q + BC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_tag_q    <= '0;
         xfer_cnt0_q <= '0;
         xfer_cnt1_q <= '0;
      end else begin
         rd_tag_q <= '{vld: xfer & ~we_i[cur_owner], owner: cur_owner};
         if (xfer && !cur_owner)
            xfer_cnt0_q <= sat_inc(xfer_cnt0_q);
         if (xfer && cur_owner)
            xfer_cnt1_q <= sat_inc(xfer_cnt1_q);
      end
   end

   assign mem_en_o       = mem_req.en;
   assign mem_we_o       = mem_req.we;
   assign mem_addr_o     = mem_req.addr;
   assign mem_wdata_lo_o = mem_req.wdata[HALF_W-1:0];
   assign mem_wdata_hi_o = mem_req.wdata[DATA_W-1:HALF_W];

   assign rvalid_o    = {rd_tag_q.vld & rd_tag_q.owner, rd_tag_q.vld & ~rd_tag_q.owner};
   assign rdata_o     = {mem_rdata_hi_i, mem_rdata_lo_i};
   assign xfer_cnt0_o = xfer_cnt0_q;
   assign xfer_cnt1_o = xfer_cnt1_q;

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16: max consecutive transfers per ownership while the other requester waits and lock is low.
REQ-002 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port req_i, input, 2: per-requester access request (bit0 = calculator controller, bit1 = host loader).
REQ-005 SHALL have port lock_i, input, 2: per-requester hold-ownership, overrides BURST_MAX.
REQ-006 SHALL have port we_i, input, 2: per-requester write enable (0 = read).
REQ-007 SHALL have ports addr0_i/addr1_i, input, ADDR_W each: requester addresses.
REQ-008 SHALL have ports wdata0_i/wdata1_i, input, 64 each: requester write data.
REQ-009 SHALL have port gnt_o, output, 2: one-hot-or-zero ownership.
REQ-010 SHALL have port rvalid_o, output, 2: per-requester read-data valid.
REQ-011 SHALL have port rdata_o, output, 64: {mem_rdata_hi_i, mem_rdata_lo_i}, broadcast.
REQ-012 SHALL have ports mem_en_o, mem_we_o (1), mem_addr_o (ADDR_W), mem_wdata_lo_o, mem_wdata_hi_o (32 each): shared to lower/upper SRAM banks.
REQ-013 SHALL have ports mem_rdata_lo_i, mem_rdata_hi_i, input, 32 each; SRAM read latency is 1 cycle.
REQ-014 SHALL have ports xfer_cnt0_o, xfer_cnt1_o, output, 16 each: saturating per-requester transfer counts.

Function
REQ-015 SHALL implement FSM states S_ARB_IDLE, S_ARB_OWN0, S_ARB_OWN1; gnt_o[n] = (state == S_ARB_OWNn).
REQ-016 SHALL perform a transfer for requester n in any cycle with req_i[n] && gnt_o[n]; mem_en_o=1, mem_we_o=we_i[n], mem_addr_o=addrn_i, mem_wdata_{hi,lo}_o = wdatan_i[63:32]/[31:0].
REQ-017 SHALL hold mem_en_o=0 and mem_we_o=0 in all non-transfer cycles; address/data outputs are don't-care there.
REQ-018 IDLE: if exactly one req_i bit set -> OWN of that requester next cycle; if both -> OWN of requester != last_owner; none -> stay (1-cycle grant latency).
REQ-019 OWNn: if req_i[n]=0 -> OWN of other if other requesting, else IDLE; no transfer occurs that cycle.
REQ-020 OWNn: burst_cnt increments per transfer; when burst_cnt reaches BURST_MAX, lock_i[n]=0 and other requesting -> switch to other OWN next cycle; if other idle, stay and clear burst_cnt.
REQ-021 lock_i[n]=1 SHALL keep OWNn regardless of burst_cnt while req_i[n]=1.
REQ-022 burst_cnt SHALL clear on every ownership change; last_owner updates on entry to OWNn.
REQ-023 rvalid_o[n] SHALL assert exactly one cycle after a read transfer of n, never for writes; both bits never set together.
REQ-024 Switching OWN0->OWN1 directly SHALL lose no pending rvalid (tag registered at transfer).
REQ-025 xfer_cntN_o SHALL increment per transfer of N, saturating at 16'hFFFF.

Reset
REQ-026 On rst: state=S_ARB_IDLE, last_owner=1 (so requester 0 wins first tie), burst_cnt=0, gnt_o=0, rvalid_o=0, mem_en_o=0, mem_we_o=0, counters=0.
REQ-027 Reset asserted mid-burst SHALL drop outstanding rvalid and ownership immediately (asynchronous).

Structure
REQ-028 arb_state_t enum and DATA_W=64 SHALL live in calculator_pkg, reusing its ADDR_W.
REQ-029 Round-robin selection SHALL be a sub-module arb_rr_pick (inputs req, last_owner; output next owner); all else in sram_port_arbiter.

Verification
REQ-030 Reset release, req_i=2'b11 same cycle -> gnt_o=2'b01 one cycle later, requester 0 writes addr 9'h000..9'h00F.
REQ-031 Both requesting continuously, lock=0, BURST_MAX=16 -> exactly 16 transfers of 0, then gnt_o=2'b10, 16 transfers of 1, alternating.
REQ-032 lock_i[0]=1, both requesting 40 cycles -> gnt_o stays 2'b01, xfer_cnt0_o=39 (1 arbitration cycle), xfer_cnt1_o=0.
REQ-033 Host writes 64'hDEAD_BEEF_0123_4567 to addr 9'h180, controller reads 9'h180 -> rvalid_o=2'b01 one cycle after read, rdata_o=64'hDEAD_BEEF_0123_4567.
REQ-034 Read by 0 on last cycle of ownership then switch -> rvalid_o[0] pulses once, rvalid_o[1] stays 0 that cycle.
REQ-035 rst asserted mid-burst -> gnt_o, rvalid_o, mem_en_o go 0 without clock edge; counters=0.
